mul_cpa_seq: RTL and testbench

//   Sequential final carry-propagate adder for the multiplier datapath.

---
 rtl/mul_cpa_seq_if.sv | 25 ++
 rtl/mul_cpa_seq.sv | 110 +++++++++++
 tb/tb_mul_cpa_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_cpa_seq_if.sv
// Valid/ready bus for the sequential carry-propagate adder.
// Upstream delivers the sum and carry rows. Downstream takes the resolved WIDTH+1 bit result.
interface mul_cpa_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_result;

  // The side that supplies the rows and consumes the result.
  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result
  );

  // The adder itself.
  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/mul_cpa_seq.sv
// Sequential final carry-propagate adder for the multiplier datapath.
// It resolves the redundant sum and carry rows into one binary value, CHUNK bits per cycle.
// A single CHUNK-bit adder is reused on every cycle, so the full carry chain stays off the critical path.
module mul_cpa_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_cpa_seq_if.slave bus,
  output logic         busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_params
    $error("mul_cpa_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH:0]   result_q;

  logic             accept;
  logic             deliver;
  logic             last_chunk;
  logic [CHUNK:0]   chunk_sum;

  // Handshake qualifiers and the adder slice for the current chunk.
  always_comb begin
    accept     = bus.in_valid && (state_q == IDLE);
    deliver    = bus.out_ready && (state_q == HOLD);
    last_chunk = (idx_q == LAST_IDX);
    chunk_sum  = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
               + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_q};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> ADD -> HOLD -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)     state_d = ADD;
      ADD:     if (last_chunk) state_d = HOLD;
      HOLD:    if (deliver)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Status and handshake outputs, decoded from the state.
  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.out_valid  = (state_q == HOLD);
    busy           = (state_q != IDLE);
    bus.out_result = result_q;
  end

  // Operand capture and chunk-serial carry propagation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= bus.in_sum;
            b_q      <= bus.in_carry;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
          end
        end
        ADD: begin
          result_q[idx_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q                        <= chunk_sum[CHUNK];
          if (last_chunk) begin
            result_q[WIDTH] <= chunk_sum[CHUNK];
            idx_q           <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_cpa_seq.sv
// Directed and randomized checks for mul_cpa_seq.
// There are two instances: one with a 32-bit width and 8-bit chunks, and one single-chunk 8-bit instance.
module tb_mul_cpa_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy32;
  logic busy8;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mul_cpa_seq_if #(.WIDTH(32)) bus32 ();
  mul_cpa_seq_if #(.WIDTH(8))  bus8 ();

  mul_cpa_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32),
    .busy  (busy32)
  );

  mul_cpa_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8),
    .busy  (busy8)
  );

  task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_fail++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one row pair to the 32-bit instance and let it be accepted.
  task automatic start32(input logic [31:0] s, input logic [31:0] c);
    int n = 0;
    while (!bus32.in_ready && n < 20) begin
      step();
      n++;
    end
    n_tests++;
    if (bus32.in_ready !== 1'b1) fail("start_ready", bus32.in_ready, 1'b1);
    bus32.in_valid = 1'b1;
    bus32.in_sum   = s;
    bus32.in_carry = c;
    step();
    bus32.in_valid = 1'b0;
    n_tests++;
    if (busy32 !== 1'b1) fail("busy_after_accept", busy32, 1'b1);
    n_tests++;
    if (bus32.in_ready !== 1'b0) fail("in_ready_after_accept", bus32.in_ready, 1'b0);
  endtask

  // Count edges until out_valid shows up, with a bounded wait.
  task automatic wait32(output int n);
    n = 0;
    while (!bus32.out_valid && n < 40) begin
      step();
      n++;
    end
    n_tests++;
    if (bus32.out_valid !== 1'b1) fail("out_valid_timeout", bus32.out_valid, 1'b1);
  endtask

  task automatic run32(input logic [31:0] s, input logic [31:0] c,
                       input logic [32:0] exp, input string tag);
    int n;
    start32(s, c);
    wait32(n);
    n_tests++;
    if (bus32.out_result !== exp) fail(tag, bus32.out_result, exp);
    n_tests++;
    if (n != 4) fail("latency32", n, 4);
    bus32.out_ready = 1'b1;
    step();
    bus32.out_ready = 1'b0;
    n_tests++;
    if (bus32.out_valid !== 1'b0) fail("out_valid_after_handshake", bus32.out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] held;
    logic [32:0] res_a;
    logic [8:0]  got8;
    logic [8:0]  exp8;
    logic [7:0]  ra;
    logic [7:0]  rb;
    int          cnt;
    int          n_a;
    int          n;
    bit          acc2;
    bit          idle_before;
    bit          done;
    bit          r;

    bus32.in_valid = 1'b0; bus32.in_sum = '0; bus32.in_carry = '0; bus32.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.in_sum  = '0; bus8.in_carry  = '0; bus8.out_ready  = 1'b0;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    n_tests++;
    if (bus32.in_ready !== 1'b1) fail("rst_in_ready", bus32.in_ready, 1'b1);
    n_tests++;
    if (bus32.out_valid !== 1'b0) fail("rst_out_valid", bus32.out_valid, 1'b0);
    n_tests++;
    if (busy32 !== 1'b0) fail("rst_busy", busy32, 1'b0);
    n_tests++;
    if (bus32.out_result !== 33'h0) fail("rst_out_result", bus32.out_result, 33'h0);
    rst_n = 1'b1;
    step();

    // Carry ripples through every chunk
    run32(32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, "ripple_all");

    // Plain patterns
    run32(32'h1234_5678, 32'h0F0F_0F0F, 33'h0_2143_6587, "pattern_mix");
    run32(32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000, "zero");

    // Backpressure in HOLD: output stays stable and new input is ignored
    start32(32'hAAAA_AAAA, 32'h5555_5555);
    wait32(n);
    held = 33'h0_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in_sum   = $urandom;
      bus32.in_carry = $urandom;
      n_tests++;
      if (bus32.out_valid !== 1'b1) fail("hold_valid", bus32.out_valid, 1'b1);
      n_tests++;
      if (bus32.out_result !== held) fail("hold_result", bus32.out_result, held);
      n_tests++;
      if (bus32.in_ready !== 1'b0) fail("hold_in_ready", bus32.in_ready, 1'b0);
      step();
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    step();
    bus32.out_ready = 1'b0;
    n_tests++;
    if (bus32.out_valid !== 1'b0) fail("hold_delivered_once", bus32.out_valid, 1'b0);
    n_tests++;
    if (bus32.in_ready !== 1'b1) fail("hold_back_idle", bus32.in_ready, 1'b1);
    step();
    n_tests++;
    if (busy32 !== 1'b0) fail("hold_no_late_accept", busy32, 1'b0);

    // Asynchronous reset while idx=2 with a pending carry
    start32(32'h0000_FFFE, 32'h0000_0003);
    step(); step();
    n_tests++;
    if (bus32.out_result !== 33'h0_0000_0001) fail("pre_reset_partial", bus32.out_result, 33'h0_0000_0001);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus32.out_result !== 33'h0) fail("midrst_out_result", bus32.out_result, 33'h0);
    n_tests++;
    if (bus32.out_valid !== 1'b0) fail("midrst_out_valid", bus32.out_valid, 1'b0);
    n_tests++;
    if (busy32 !== 1'b0) fail("midrst_busy", busy32, 1'b0);
    n_tests++;
    if (bus32.in_ready !== 1'b1) fail("midrst_in_ready", bus32.in_ready, 1'b1);
    #2;
    rst_n = 1'b1;
    step();
    run32(32'hFFFF_0000, 32'h0000_FFFF, 33'h0_FFFF_FFFF, "no_stale_carry");

    // Back-to-back operations with in_valid held high
    bus32.out_ready = 1'b1;
    bus32.in_valid  = 1'b1;
    bus32.in_sum    = 32'h1234_5678;
    bus32.in_carry  = 32'h8765_4321;
    step();
    bus32.in_sum   = 32'h8000_0000;
    bus32.in_carry = 32'h8000_0000;
    cnt = 0; n_a = 0; acc2 = 1'b0; res_a = '0;
    while (!acc2 && cnt < 20) begin
      idle_before = bus32.in_ready;
      if (bus32.out_valid) begin
        res_a = bus32.out_result;
        n_a++;
      end
      step();
      cnt++;
      if (idle_before) acc2 = 1'b1;
    end
    bus32.in_valid = 1'b0;
    n_tests++;
    if (cnt != 6) fail("b2b_accept_gap", cnt, 6);
    n_tests++;
    if (res_a !== 33'h0_9999_9999) fail("b2b_first_result", res_a, 33'h0_9999_9999);
    n_tests++;
    if (n_a != 1) fail("b2b_first_once", n_a, 1);
    wait32(n);
    n_tests++;
    if (n != 4) fail("b2b_second_latency", n, 4);
    n_tests++;
    if (bus32.out_result !== 33'h1_0000_0000) fail("b2b_second_result", bus32.out_result, 33'h1_0000_0000);
    step();
    bus32.out_ready = 1'b0;
    n_tests++;
    if (bus32.out_valid !== 1'b0) fail("b2b_done", bus32.out_valid, 1'b0);

    // Single-chunk instance
    bus8.in_valid = 1'b1;
    bus8.in_sum   = 8'hFF;
    bus8.in_carry = 8'hFF;
    step();
    bus8.in_valid = 1'b0;
    n_tests++;
    if (bus8.out_valid !== 1'b0) fail("w8_not_yet", bus8.out_valid, 1'b0);
    step();
    n_tests++;
    if (bus8.out_valid !== 1'b1) fail("w8_latency", bus8.out_valid, 1'b1);
    n_tests++;
    if (bus8.out_result !== 9'h1FE) fail("w8_ff_ff", bus8.out_result, 9'h1FE);
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    n_tests++;
    if (bus8.out_valid !== 1'b0) fail("w8_released", bus8.out_valid, 1'b0);

    // Random operands with random backpressure, out_ready also toggling outside HOLD
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      bus8.in_valid = 1'b1;
      bus8.in_sum   = ra;
      bus8.in_carry = rb;
      step();
      bus8.in_valid = 1'b0;
      done = 1'b0;
      got8 = '0;
      for (int k = 0; k < 64 && !done; k++) begin
        r = 1'($urandom_range(0, 1));
        bus8.out_ready = r;
        if (bus8.out_valid && r) begin
          got8 = bus8.out_result;
          done = 1'b1;
        end
        step();
      end
      bus8.out_ready = 1'b0;
      exp8 = {1'b0, ra} + {1'b0, rb};
      n_tests++;
      if (done !== 1'b1) fail("rand_delivered", done, 1'b1);
      n_tests++;
      if (got8 !== exp8) fail("rand_sum", got8, exp8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
